// File: rtl/ram_dual_pkg.sv
// Shared constants and clear-FSM state type for the ram_dual memory.
package ram_dual_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 6;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_dual_if.sv
// Write/read bus of ram_dual; the memory sits on the slave modport.
interface ram_dual_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) ();
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] q;
    logic                  busy;

    modport master (
        output data, write_addr, read_addr, we,
        input  q, busy
    );

    modport slave (
        input  data, write_addr, read_addr, we,
        output q, busy
    );
endinterface

// File: rtl/ram_dual_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once, writing zero.
//   state | meaning
//   CLEAR | zeroing mem[clr_cnt], busy high
//   IDLE  | clear done, user access allowed
module ram_dual_clear_ctrl
    import ram_dual_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    clr_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        clr_we      = 1'b0;
        case (state)
            CLEAR: begin
                busy        = 1'b1;
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) state_nxt = IDLE;
            end
            IDLE: ;
            default: state_nxt = CLEAR;
        endcase
    end

    assign clr_addr = clr_cnt;
endmodule

// File: rtl/ram_dual.sv
// Single-clock simple dual-port RAM with registered read and self-clear after reset.
// Define RAM_DUAL_BYPASS_EN for write-first same-address reads (default: old data).
module ram_dual
    import ram_dual_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic    clock,
    input  logic    reset,
    ram_dual_if.slave bus
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q_r;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;

    ram_dual_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clear_ctrl (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // User writes are locked out while clearing and in the reset cycle itself.
    always_ff @(posedge clock) begin
        if (clr_we && !reset)
            mem[clr_addr] <= '0;
        else if (bus.we && !busy && !reset)
            mem[bus.write_addr] <= bus.data;
    end

    always_ff @(posedge clock) begin
        if (reset || busy)
            q_r <= '0;
`ifdef RAM_DUAL_BYPASS_EN
        else if (bus.we && (bus.read_addr == bus.write_addr))
            q_r <= bus.data;
`endif
        else
            q_r <= mem[bus.read_addr];
    end

    assign bus.q    = q_r;
    assign bus.busy = busy;
endmodule

// File: tb/tb_ram_dual.sv
// Scoreboard bench for ram_dual: reference memory model, expected reads queued and popped.
module tb_ram_dual;
    logic clock = 1'b0;
    logic reset;

    ram_dual_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

    ram_dual dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] model [64];
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
    endtask

    // One clock of traffic; optionally queue the read result and check it after the edge.
    task automatic cyc(input logic w, input logic [5:0] wa, input logic [7:0] d,
                       input logic [5:0] ra, input bit chk, input string tag);
        logic [7:0] e;
        bus.we = w; bus.write_addr = wa; bus.data = d; bus.read_addr = ra;
        e = model[ra];
`ifdef RAM_DUAL_BYPASS_EN
        if (w && wa == ra) e = d;
`endif
        if (chk) exp_q.push_back(e);
        if (w) model[wa] = d;
        @(posedge clock); #1;
        if (chk) begin
            if (exp_q.size() == 0) check({tag, "_empty"}, 1, 0);
            else check(tag, bus.q, exp_q.pop_front());
        end
    endtask

    // Counts edges until busy falls; optionally presses a write to address 3 mid-clear.
    task automatic clear_len(input bit inject, output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            if (inject && n == 10) begin
                bus.we = 1'b1; bus.write_addr = 6'd3; bus.data = 8'hFF;
            end
            if (n == 32) check("q_zero_busy", bus.q, 0);
            @(posedge clock); #1;
            n++;
        end
        bus.we = 1'b0;
        model_clear();
    endtask

    int n;

    initial begin
        reset = 1'b1;
        bus.we = 1'b0; bus.data = '0; bus.write_addr = '0; bus.read_addr = '0;
        @(posedge clock); #1;
        check("rst_busy", bus.busy, 1);
        check("rst_q", bus.q, 0);
        reset = 1'b0;

        clear_len(1'b1, n);
        check("clear_len", n, 64);
        check("busy_done", bus.busy, 0);

        for (int a = 0; a < 64; a++) cyc(1'b0, 6'd0, 8'h00, 6'(a), 1'b1, "zero_rd");

        cyc(1'b1, 6'd10, 8'hA5, 6'd0, 1'b0, "");
        cyc(1'b0, 6'd0, 8'h00, 6'd10, 1'b1, "rd_a10");

        cyc(1'b1, 6'd63, 8'h3C, 6'd1, 1'b0, "");
        cyc(1'b1, 6'd0, 8'h11, 6'd2, 1'b0, "");
        cyc(1'b0, 6'd0, 8'h00, 6'd63, 1'b1, "rd_a63");
        cyc(1'b0, 6'd0, 8'h00, 6'd0, 1'b1, "rd_a0");

        cyc(1'b1, 6'd5, 8'h22, 6'd0, 1'b0, "");
        cyc(1'b1, 6'd5, 8'h77, 6'd5, 1'b1, "rdw_a5");
        cyc(1'b0, 6'd0, 8'h00, 6'd5, 1'b1, "rd_a5_after");
        cyc(1'b1, 6'd6, 8'h44, 6'd10, 1'b1, "rd_other");

        // Reset with a write presented, then reset again at clear count 30.
        bus.we = 1'b1; bus.write_addr = 6'd7; bus.data = 8'h99;
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst2_q", bus.q, 0);
        check("rst2_busy", bus.busy, 1);
        bus.we = 1'b0;
        reset = 1'b0;
        repeat (30) begin @(posedge clock); #1; end
        check("mid_busy", bus.busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        clear_len(1'b0, n);
        check("restart_len", n, 64);
        cyc(1'b0, 6'd0, 8'h00, 6'd7, 1'b1, "rd_a7");
        cyc(1'b0, 6'd0, 8'h00, 6'd10, 1'b1, "rd_a10_clr");

        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom),
                6'($urandom_range(0, 7)), 1'b1, "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_dual.md
RAM_DUAL -- requirements
Module: ram_dual

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH SHALL default to 8 and set the word width.
REQ-003 Parameter ADDR_WIDTH SHALL default to 6 and set the address width.
REQ-004 Parameter DEPTH SHALL default to 2**ADDR_WIDTH (64) and set the number of words.
REQ-005 Port clock SHALL be an input, 1 bit wide: the single rising-edge clock for all logic.
REQ-006 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-007 Port data SHALL be an input, DATA_WIDTH bits wide: write data.
REQ-008 Port write_addr SHALL be an input, ADDR_WIDTH bits wide: write address.
REQ-009 Port read_addr SHALL be an input, ADDR_WIDTH bits wide: read address.
REQ-010 Port we SHALL be an input, 1 bit wide: write enable, active-high.
REQ-011 Port q SHALL be an output, DATA_WIDTH bits wide: registered read data.
REQ-012 Port busy SHALL be an output, 1 bit wide: high while the post-reset memory clear is in progress.

Function
REQ-013 Storage SHALL be DEPTH words of DATA_WIDTH bits; every address 0..DEPTH-1 is valid, so no out-of-range access exists.
REQ-014 On a rising clock edge with we=1 and busy=0, mem[write_addr] SHALL be loaded with data.
REQ-015 On every rising clock edge with busy=0, q SHALL be loaded with mem[read_addr] (read latency of 1 cycle).
REQ-016 When read_addr == write_addr and we=1 in the same cycle, q SHALL return the old contents (read-before-write), unless REQ-026 applies.
REQ-017 A write to one address SHALL NOT alter q for reads of any other address.
REQ-018 The clear FSM SHALL have two states: CLEAR (busy=1) and IDLE (busy=0).
REQ-019 In CLEAR, on each clock edge, mem[clr_cnt] SHALL be written with 0 and clr_cnt incremented; when clr_cnt == DEPTH-1, the FSM SHALL move to IDLE.
REQ-020 While busy=1, the we input SHALL be ignored and q SHALL hold 0.
REQ-021 After reset is released, busy SHALL remain high for exactly DEPTH cycles, and the first user write SHALL be accepted on the next edge.

Reset
REQ-022 While reset=1 at a clock edge, the block SHALL set q=0, set the state to CLEAR (busy=1) and set clr_cnt=0.
REQ-023 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-024 Reset asserted during normal operation SHALL discard any write presented in that cycle.

Configuration
REQ-025 The macro RAM_DUAL_BYPASS_EN SHALL select the read-during-write behaviour.
REQ-026 With RAM_DUAL_BYPASS_EN defined, a same-address read and write in one cycle SHALL load q with the new data (write-first).
REQ-027 Without RAM_DUAL_BYPASS_EN defined, the behaviour of REQ-016 (old data) SHALL apply.

Structure
REQ-028 Package ram_dual_pkg SHALL hold the default DATA_WIDTH and ADDR_WIDTH constants and the clear-FSM state typedef (CLEAR, IDLE).
REQ-029 The clear FSM and its counter SHALL be a sub-module, ram_dual_clear_ctrl, which outputs busy, the clear address and the clear write strobe.
REQ-030 The storage array and the read register SHALL be in ram_dual.

Verification
REQ-031 Reset held for 1 cycle, then released -> busy=1 for 64 cycles, then 0; reading every address afterward returns 0x00.
REQ-032 Write 0xA5 to address 10, then read address 10 -> q=0xA5 one cycle after read_addr is presented.
REQ-033 Write 0x3C to address 63 and 0x11 to address 0, then read both -> 0x3C and 0x11 (no wrap-around aliasing).
REQ-034 With address 5 holding 0x22, write 0x77 to address 5 while reading address 5 in the same cycle -> q=0x22 without the macro, 0x77 with RAM_DUAL_BYPASS_EN.
REQ-035 Assert we with 0xFF to address 3 while busy=1, then read address 3 after the clear completes -> q=0x00.
REQ-036 Assert reset at clear count 30, then release -> busy stays high for a further 64 cycles.
